// File: rtl/icache_pkg.sv
// Shared types and constants for the instruction cache: word type,
// address view and frame layout for the default 16-frame geometry.
package icache_pkg;
  localparam int WORD_W = 32;
  localparam int IIDX_W = 4;
  localparam int ITAG_W = WORD_W - IIDX_W - 2;

  typedef logic [WORD_W-1:0] word_t;

  typedef struct packed {
    logic [ITAG_W-1:0] tag;
    logic [IIDX_W-1:0] idx;
    logic [1:0]        bytoff;
  } icachef_t;

  typedef struct packed {
    logic              valid;
    logic [ITAG_W-1:0] tag;
    word_t             data;
  } icache_frame_t;
endpackage

// File: rtl/icache_if.sv
// Datapath fetch port and memory-controller fill port of the icache.
// slave: the cache itself; master: whatever drives requests and memory.
interface icache_if;
  import icache_pkg::*;

  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;
  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, read-only, one-word-per-block instruction cache.
// Hits are answered combinationally in IDLE; a miss latches the word
// address and holds a single-word read until memory drops iwait.
module icache
  import icache_pkg::*;
#(
  parameter int FRAMES = 16
) (
  input logic     CLK,
  input logic     nRST,
  icache_if.slave bus
);
  localparam int IW = $clog2(FRAMES);
  localparam int TW = 30 - IW;

  typedef enum logic {IDLE, FETCH} icache_state_t;

  icache_state_t     state;
  logic [FRAMES-1:0] valid;
  logic [TW-1:0]     tags [FRAMES];
  word_t             data [FRAMES];
  logic [29:0]       miss_addr;
  logic              iren_r;
  word_t             iaddr_r;

  logic [IW-1:0] req_idx;
  logic [TW-1:0] req_tag;
  logic [IW-1:0] miss_idx;
  logic [TW-1:0] miss_tag;
  logic          hit;
  logic          fill;
  logic          unused_bytoff;

  assign req_idx  = bus.imemaddr[IW+1:2];
  assign req_tag  = bus.imemaddr[31:IW+2];
  assign miss_idx = miss_addr[IW-1:0];
  assign miss_tag = miss_addr[29:IW];
  assign unused_bytoff = ^bus.imemaddr[1:0];

  assign hit  = bus.imemREN && (state == IDLE) && valid[req_idx] &&
                (tags[req_idx] == req_tag);
  assign fill = (state == FETCH) && !bus.iwait;

  assign bus.ihit     = hit;
  assign bus.imemload = hit ? data[req_idx] : '0;
  assign bus.iREN     = iren_r;
  assign bus.iaddr    = iaddr_r;

  // Control FSM: valid bits, miss latch and registered fill request.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= IDLE;
      valid     <= '0;
      miss_addr <= '0;
      iren_r    <= 1'b0;
      iaddr_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.imemREN && !hit) begin
            state     <= FETCH;
            miss_addr <= bus.imemaddr[31:2];
            iren_r    <= 1'b1;
            iaddr_r   <= {bus.imemaddr[31:2], 2'b00};
          end
        end
        FETCH: begin
          if (!bus.iwait) begin
            state           <= IDLE;
            valid[miss_idx] <= 1'b1;
            iren_r          <= 1'b0;
            iaddr_r         <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Frame storage: tag and data are only meaningful under valid, so no reset.
  always_ff @(posedge CLK) begin
    if (fill) begin
      data[miss_idx] <= bus.iload;
      tags[miss_idx] <= miss_tag;
    end
  end
endmodule
